// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared constants and FSM encoding for the UART TX arbiter.
// Optional feature macro: UART_TX_ARB_PARITY_EN (adds an even-parity bit
// between the data bits and the stop bit).
package uart_arb_pkg;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_NO_PARITY = 10;
  localparam int FRAME_BITS_PARITY    = 11;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_ARB_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;
endpackage

// File: rtl/uart_tx_shift.sv
// uart_tx_shift: UART serialiser (start, 8 data bits LSB first, optional
// even parity, stop). Owns the FSM, bit-time counter, bit index and line.
// Ports:
//   clk, reset   clock, async active-high reset
//   i_start      accept i_data this cycle (only honoured in IDLE)
//   i_data       byte to send
//   o_busy       high in every non-IDLE state (registered)
//   o_tx         serial line, idle high (registered)
// Macro: UART_TX_ARB_PARITY_EN inserts the PARITY state.
module uart_tx_shift
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_busy,
  output logic                 o_tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_tx;
  logic                 r_busy;

  logic                 w_bit_end;
  logic [2:0]           w_idx_nxt;

  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_idx_nxt = r_idx + 3'd1;   // wraps 7 -> 0 on leaving DATA
  assign o_busy    = r_busy;
  assign o_tx      = r_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      // Outputs are set one state ahead so the line changes exactly on
      // the bit boundary without a combinational decode.
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_start) begin
            r_data  <= i_data;
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
            r_tx    <= r_data[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            r_idx <= w_idx_nxt;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= ^r_data;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_tx <= r_data[w_idx_nxt];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_TX_ARB_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two valid/ready requesters (0 = CPU, 1 = debug) sharing
// one UART transmitter with round-robin arbitration.
// Ports:
//   clk, reset               clock, async active-high reset
//   req0_valid/data/ready    CPU requester
//   req1_valid/data/ready    debug requester
//   UART_TX                  serial line, idle high
//   busy                     frame in progress
//   last_grant               index of most recently granted requester
// Macro: UART_TX_ARB_PARITY_EN (passed through to the serialiser).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 UART_TX,
  output logic                 busy,
  output logic                 last_grant
);
  logic                 r_last_grant;
  logic                 w_busy;
  logic                 w_win;
  logic                 w_open;
  logic                 w_xfer;
  logic [DATA_BITS-1:0] w_data;

  // Tie goes to whoever was not served last; reset value 1 favours req0.
  assign w_win  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_open = ~w_busy & ~reset;

  assign req0_ready = w_open & req0_valid & ~w_win;
  assign req1_ready = w_open & req1_valid &  w_win;
  assign w_xfer     = req0_ready | req1_ready;
  assign w_data     = w_win ? req1_data : req0_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_last_grant <= 1'b1;
    else if (w_xfer) r_last_grant <= w_win;
  end

  uart_tx_shift #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_xfer),
    .i_data  (w_data),
    .o_busy  (w_busy),
    .o_tx    (UART_TX)
  );

  assign busy       = w_busy;
  assign last_grant = r_last_grant;
endmodule
